add_seq_ctrl: RTL and testbench
===============================

Name: add_seq_ctrl

Overview:
- Multi-cycle wide add/subtract sequencer built around one shared N-bit ripple-carry slice of full-adder cells.
- Accepts W-bit operands over a valid/ready handshake and feeds the slice one N-bit chunk per cycle, least significant chunk first.
- Registers the inter-chunk carry and assembles the W-bit result, so wide arithmetic costs one N-bit adder instead of a W-bit one.
- Sits between the operand source (ALU issue logic) and the result consumer.

Parameters:
- W, 64, operand/result width in bits; must be an integer multiple of N with W >= N, otherwise elaboration fails.
- N, 16, adder slice width in bits; the number of beats is K = W/N.

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- rst, input, 1, synchronous active-high reset.
- in_valid, input, 1, operand request valid.
- in_ready, output, 1, controller can accept an operand request.
- a, input, W, operand A; sampled on accept.
- b, input, W, operand B; sampled on accept.
- sub, input, 1, 0 = A+B, 1 = A−B; sampled on accept.
- out_valid, output, 1, result valid.
- out_ready, input, 1, consumer accepts the result.
- sum, output, W, result.
- cout, output, 1, carry out of bit W−1 (for subtract, 1 = no borrow).

Behaviour:
- Reset and mid-operation reset: rst=1 at any edge returns the FSM to IDLE and clears all registered state.
  - in_ready=1, out_valid=0, sum=0, cout=0, beat counter=0.
  - Any in-flight operation is discarded; no result is produced for it.
- State IDLE:
  - in_ready=1, out_valid=0.
  - On in_valid&&in_ready: latch a; latch b, inverted bitwise when sub=1; carry register <= sub; beat <= 0; go to RUN.
- State RUN:
  - in_ready=0; in_valid is ignored.
  - Each cycle the slice computes chunk[beat] of A + chunk[beat] of B' + carry.
  - The slice sum is shifted into the result register from the top; the result register shifts right by N.
  - carry <= slice carry-out; beat <= beat+1.
  - On the edge that processes beat K−1: cout <= slice carry-out, go to DONE.
- State DONE:
  - out_valid=1; sum and cout are held stable.
  - out_ready=0: stay in DONE, outputs unchanged indefinitely.
  - out_ready=1: transfer completes; go to IDLE next edge. out_valid drops; sum/cout keep their last value.
- Latency and throughput:
  - Accept at edge 0; out_valid is high from edge K.
  - Minimum initiation interval is K+1 cycles. Accept and result never overlap; no pipelining.
- Arithmetic:
  - Result modulo 2^W.
  - Subtract is A + ~B + 1, implemented through the initial carry.
  - Beat counter width is clog2(K), minimum 1 bit.
  - K=1 (W=N) is legal: RUN lasts exactly one cycle.
- Simultaneous events:
  - rst has priority over every handshake.
  - in_valid asserted while in DONE with out_ready=1 is not accepted in that cycle, because in_ready=0.

Optional Feature:
- Macro: ADD_SEQ_CTRL_OVF_EN.
- When defined:
  - Adds output port ovf (1 bit) = signed overflow = carry into bit W−1 XOR carry out of bit W−1, using the slice's internal carry chain on beat K−1.
  - ovf is registered alongside cout, valid with out_valid, and reset to 0.
- When undefined: the port and its logic are absent; all other behaviour is identical.

Test Plan:
- W=64,N=16: a=0xFFFFFFFFFFFFFFFF, b=1, sub=0 accepted at edge 0 -> out_valid at edge 4, sum=0, cout=1; in_ready=0 on edges 1–4.
- a=5, b=7, sub=1 -> sum=0xFFFFFFFFFFFFFFFE, cout=0; then a=7, b=5, sub=1 -> sum=2, cout=1.
- a=0x0000FFFF0000FFFF, b=0x0000000100000001, sub=0, out_ready held 0 for 3 cycles after out_valid:
  - sum=0x0001000000010000 stable throughout, in_ready=0.
  - out_ready=1 -> IDLE next cycle, in_ready=1.
- Back-to-back traffic: in_valid held 1 with new operands while busy -> only the first is accepted; the second is accepted on the first IDLE cycle (K+1 cycles after the first).
- rst pulsed for 1 cycle during RUN beat 2 -> next cycle in_ready=1, out_valid=0, sum=0, cout=0; no stale result ever appears.
- With ADD_SEQ_CTRL_OVF_EN:
  - a=0x7FFFFFFFFFFFFFFF, b=1, sub=0 -> sum=0x8000000000000000, ovf=1, cout=0.
  - a=1, b=1, sub=1 -> sum=0, ovf=0, cout=1.

Source files
------------

// File: rtl/add_seq_ctrl.sv
// Multi-cycle W-bit add/subtract built on one shared N-bit ripple slice.
// Optional signed-overflow output when ADD_SEQ_CTRL_OVF_EN is defined.
module add_seq_ctrl #(
  parameter int W = 64,
  parameter int N = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         sub,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] sum,
`ifdef ADD_SEQ_CTRL_OVF_EN
  output logic         ovf,
`endif
  output logic         cout
);

  localparam int K  = W / N;
  localparam int BW = (K > 1) ? $clog2(K) : 1;
  localparam logic [BW-1:0] LAST = BW'(K - 1);

  if ((W % N) != 0 || W < N) begin : g_bad_cfg
    $error("add_seq_ctrl: W must be a multiple of N and W >= N");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  a_q, a_d;
  logic [W-1:0]  b_q, b_d;
  logic          c_q, c_d;
  logic [BW-1:0] beat_q, beat_d;
  logic [W-1:0]  res_q, res_d;
  logic          cout_q, cout_d;
`ifdef ADD_SEQ_CTRL_OVF_EN
  logic          ovf_q, ovf_d;
  logic [N-1:0]  cin_vec;
`endif

  // Ripple chain of full-adder cells; returns {carry_out, sum}.
  function automatic logic [N:0] slice_f(
    input logic [N-1:0] x,
    input logic [N-1:0] y,
    input logic         ci
  );
    logic         c;
    logic [N-1:0] s;
    c = ci;
    for (int i = 0; i < N; i++) begin
      s[i] = x[i] ^ y[i] ^ c;
      c    = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
    end
    return {c, s};
  endfunction

  logic [N-1:0] sl_sum;
  logic         sl_co;
  logic [W-1:0] res_sh;

  assign {sl_co, sl_sum} = slice_f(a_q[N-1:0], b_q[N-1:0], c_q);

`ifdef ADD_SEQ_CTRL_OVF_EN
  // Carry into the slice MSB is recovered from the sum bit.
  assign cin_vec = a_q[N-1:0] ^ b_q[N-1:0] ^ sl_sum;
`endif

  if (K == 1) begin : g_k1
    assign res_sh = sl_sum;
  end else begin : g_kn
    assign res_sh = {sl_sum, res_q[W-1:N]};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= 1'b0;
      beat_q  <= '0;
      res_q   <= '0;
      cout_q  <= 1'b0;
`ifdef ADD_SEQ_CTRL_OVF_EN
      ovf_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      c_q     <= c_d;
      beat_q  <= beat_d;
      res_q   <= res_d;
      cout_q  <= cout_d;
`ifdef ADD_SEQ_CTRL_OVF_EN
      ovf_q   <= ovf_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    c_d       = c_q;
    beat_d    = beat_q;
    res_d     = res_q;
    cout_d    = cout_q;
`ifdef ADD_SEQ_CTRL_OVF_EN
    ovf_d     = ovf_q;
`endif
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub;
          beat_d  = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d    = a_q >> N;
        b_d    = b_q >> N;
        c_d    = sl_co;
        res_d  = res_sh;
        beat_d = beat_q + 1'b1;
        if (beat_q == LAST) begin
          cout_d  = sl_co;
`ifdef ADD_SEQ_CTRL_OVF_EN
          ovf_d   = cin_vec[N-1] ^ sl_co;
`endif
          state_d = DONE;
        end
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign sum  = res_q;
  assign cout = cout_q;
`ifdef ADD_SEQ_CTRL_OVF_EN
  assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_add_seq_ctrl.sv
// Randomized and directed bench for add_seq_ctrl (W=64, N=16).
// Reference results come from plain 65-bit arithmetic.
module tb_add_seq_ctrl;

  localparam int W = 64;
  localparam int N = 16;
  localparam int K = W / N;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
`ifdef ADD_SEQ_CTRL_OVF_EN
  logic         ovf;
`endif

  int tests;
  int fails;

  add_seq_ctrl #(.W(W), .N(N)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
`ifdef ADD_SEQ_CTRL_OVF_EN
    .ovf      (ovf),
`endif
    .cout     (cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic logic [W:0] model_res(
    input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W:0] r;
    if (s) begin
      r[W-1:0] = x - y;
      r[W]     = (x >= y);
    end else begin
      r = {1'b0, x} + {1'b0, y};
    end
    return r;
  endfunction

  function automatic logic model_ovf(
    input logic [W-1:0] x, input logic [W-1:0] y, input logic s);
    logic [W-1:0] r;
    r = s ? x - y : x + y;
    if (s) return (x[W-1] != y[W-1]) && (r[W-1] != x[W-1]);
    return (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
  endfunction

  // Issue one op from IDLE, wait for the result, hold it for stall
  // cycles, then hand it off. bad counts protocol violations seen.
  task automatic do_op(
    input  logic [W-1:0] xa, input logic [W-1:0] xb, input logic xs,
    input  int stall,
    output logic [W-1:0] rs, output logic rc, output logic ro,
    output int lat, output int bad);
    in_valid = 1'b1;
    a = xa;
    b = xb;
    sub = xs;
    @(posedge clk); #1;
    in_valid = 1'b0;
    a = {$urandom(), $urandom()};
    b = {$urandom(), $urandom()};
    sub = 1'($urandom_range(0, 1));
    lat = 0;
    bad = 0;
    while (!out_valid && lat < 50) begin
      @(posedge clk); #1;
      lat++;
      if (in_ready) bad++;
    end
    rs = sum;
    rc = cout;
`ifdef ADD_SEQ_CTRL_OVF_EN
    ro = ovf;
`else
    ro = 1'b0;
`endif
    repeat (stall) begin
      @(posedge clk); #1;
      if (sum !== rs || cout !== rc || out_valid !== 1'b1 || in_ready !== 1'b0)
        bad++;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      fails++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b want 1 0",
               in_ready, out_valid);
    end
    tests++;
    if (sum !== '0 || cout !== 1'b0) begin
      fails++;
      $display("FAIL reset_out: sum=%h cout=%b want 0 0", sum, cout);
    end
`ifdef ADD_SEQ_CTRL_OVF_EN
    tests++;
    if (ovf !== 1'b0) begin
      fails++;
      $display("FAIL reset_ovf: ovf=%b want 0", ovf);
    end
`endif
    rst = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    logic [W-1:0] va[3];
    logic [W-1:0] vb[3];
    logic         vs[3];
    logic [W-1:0] es[3];
    logic         ec[3];
    logic [W-1:0] rs;
    logic rc, ro;
    int lat, bad;
    va = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd5, 64'd7};
    vb = '{64'd1, 64'd7, 64'd5};
    vs = '{1'b0, 1'b1, 1'b1};
    es = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'd2};
    ec = '{1'b1, 1'b0, 1'b1};
    for (int i = 0; i < 3; i++) begin
      do_op(va[i], vb[i], vs[i], 0, rs, rc, ro, lat, bad);
      tests++;
      if (rs !== es[i] || rc !== ec[i]) begin
        fails++;
        $display("FAIL directed_%0d: sum=%h cout=%b want %h %b",
                 i, rs, rc, es[i], ec[i]);
      end
      tests++;
      if (lat != K || bad != 0) begin
        fails++;
        $display("FAIL directed_lat_%0d: lat=%0d busy_err=%0d want %0d 0",
                 i, lat, bad, K);
      end
      tests++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
        fails++;
        $display("FAIL directed_idle_%0d: in_ready=%b out_valid=%b want 1 0",
                 i, in_ready, out_valid);
      end
    end
  endtask

  task automatic test_stall();
    logic [W-1:0] rs;
    logic rc, ro;
    int lat, bad;
    do_op(64'h0000_FFFF_0000_FFFF, 64'h0000_0001_0000_0001, 1'b0, 3,
          rs, rc, ro, lat, bad);
    tests++;
    if (rs !== 64'h0001_0000_0001_0000 || rc !== 1'b0) begin
      fails++;
      $display("FAIL stall_sum: sum=%h cout=%b want 0001000000010000 0",
               rs, rc);
    end
    tests++;
    if (bad != 0 || lat != K) begin
      fails++;
      $display("FAIL stall_hold: violations=%0d lat=%0d want 0 %0d",
               bad, lat, K);
    end
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        sum !== 64'h0001_0000_0001_0000) begin
      fails++;
      $display("FAIL stall_release: in_ready=%b out_valid=%b sum=%h want 1 0 0001000000010000",
               in_ready, out_valid, sum);
    end
  endtask

  task automatic test_back_to_back();
    logic [W-1:0] a1, b1, a2, b2, s1, s2;
    logic [W:0] e1, e2;
    logic c1, c2;
    int cnt, ovs, lat2;
    a1 = {$urandom(), $urandom()};
    b1 = {$urandom(), $urandom()};
    a2 = {$urandom(), $urandom()};
    b2 = {$urandom(), $urandom()};
    e1 = model_res(a1, b1, 1'b0);
    e2 = model_res(a2, b2, 1'b1);
    s1 = '0;
    c1 = 1'b0;
    out_ready = 1'b1;
    in_valid = 1'b1;
    a = a1;
    b = b1;
    sub = 1'b0;
    @(posedge clk); #1;
    a = a2;
    b = b2;
    sub = 1'b1;
    cnt = 0;
    ovs = 0;
    while (cnt < 50) begin
      @(posedge clk); #1;
      cnt++;
      if (out_valid) begin
        ovs++;
        s1 = sum;
        c1 = cout;
      end
      if (in_ready) break;
    end
    tests++;
    if (cnt != K + 1 || ovs != 1) begin
      fails++;
      $display("FAIL b2b_gap: idle_after=%0d results=%0d want %0d 1",
               cnt, ovs, K + 1);
    end
    tests++;
    if (s1 !== e1[W-1:0] || c1 !== e1[W]) begin
      fails++;
      $display("FAIL b2b_first: sum=%h cout=%b want %h %b",
               s1, c1, e1[W-1:0], e1[W]);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat2 = 0;
    while (!out_valid && lat2 < 50) begin
      @(posedge clk); #1;
      lat2++;
    end
    s2 = sum;
    c2 = cout;
    tests++;
    if (s2 !== e2[W-1:0] || c2 !== e2[W] || lat2 != K) begin
      fails++;
      $display("FAIL b2b_second: sum=%h cout=%b lat=%0d want %h %b %0d",
               s2, c2, lat2, e2[W-1:0], e2[W], K);
    end
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  task automatic test_mid_reset();
    int stale;
    in_valid = 1'b1;
    a = 64'h1234_5678_9ABC_DEF0;
    b = 64'h0FED_CBA9_8765_4321;
    sub = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    tests++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 ||
        sum !== '0 || cout !== 1'b0) begin
      fails++;
      $display("FAIL midrst_state: in_ready=%b out_valid=%b sum=%h cout=%b want 1 0 0 0",
               in_ready, out_valid, sum, cout);
    end
    stale = 0;
    repeat (K + 3) begin
      @(posedge clk); #1;
      if (out_valid) stale++;
    end
    tests++;
    if (stale != 0) begin
      fails++;
      $display("FAIL midrst_stale: result cycles=%0d want 0", stale);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] xa, xb, rs;
    logic [W:0] e;
    logic xs, rc, ro, eo;
    logic [W-1:0] corner[4];
    int lat, bad;
    corner = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFF,
               64'h8000_0000_0000_0000, 64'h7FFF_FFFF_FFFF_FFFF};
    for (int i = 0; i < 30; i++) begin
      xa = {$urandom(), $urandom()};
      xb = {$urandom(), $urandom()};
      if ($urandom_range(0, 3) == 0) xa = corner[$urandom_range(0, 3)];
      if ($urandom_range(0, 3) == 0) xb = corner[$urandom_range(0, 3)];
      xs = 1'($urandom_range(0, 1));
      e  = model_res(xa, xb, xs);
      eo = model_ovf(xa, xb, xs);
      do_op(xa, xb, xs, $urandom_range(0, 2), rs, rc, ro, lat, bad);
      tests++;
      if (rs !== e[W-1:0] || rc !== e[W] || lat != K || bad != 0) begin
        fails++;
        $display("FAIL rand_%0d: a=%h b=%h sub=%b sum=%h cout=%b lat=%0d err=%0d want %h %b %0d 0",
                 i, xa, xb, xs, rs, rc, lat, bad, e[W-1:0], e[W], K);
      end
`ifdef ADD_SEQ_CTRL_OVF_EN
      tests++;
      if (ro !== eo) begin
        fails++;
        $display("FAIL rand_ovf_%0d: ovf=%b want %b", i, ro, eo);
      end
`else
      if (ro !== 1'b0 && eo === 1'bx) tests++;
`endif
    end
  endtask

`ifdef ADD_SEQ_CTRL_OVF_EN
  task automatic test_ovf();
    logic [W-1:0] rs;
    logic rc, ro;
    int lat, bad;
    do_op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 0, rs, rc, ro, lat, bad);
    tests++;
    if (rs !== 64'h8000_0000_0000_0000 || ro !== 1'b1 || rc !== 1'b0) begin
      fails++;
      $display("FAIL ovf_pos: sum=%h ovf=%b cout=%b want 8000000000000000 1 0",
               rs, ro, rc);
    end
    do_op(64'd1, 64'd1, 1'b1, 0, rs, rc, ro, lat, bad);
    tests++;
    if (rs !== '0 || ro !== 1'b0 || rc !== 1'b1) begin
      fails++;
      $display("FAIL ovf_zero: sum=%h ovf=%b cout=%b want 0 0 1", rs, ro, rc);
    end
  endtask
`endif

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    a = '0;
    b = '0;
    sub = 1'b0;
    test_reset();
    test_directed();
    test_stall();
    test_back_to_back();
    test_mid_reset();
    test_random();
`ifdef ADD_SEQ_CTRL_OVF_EN
    test_ovf();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
